// File: rtl/ppu_reg_if.sv
// ppu_reg_if: CPU-facing register file of an NES-style picture processing unit.
// Decodes eight registers (CTRL, MASK, STATUS, OAMADDR, OAMDATA, SCROLL, ADDR, DATA),
// keeps the renderer status flags and drives the OAM and VRAM access ports.
// Build option: define PPU_READ_BUFFER_EN for the NES one-read-delay DATA read buffer;
// without it a DATA read returns its own VRAM byte two cycles after the access.
module ppu_reg_if (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  cpu_addr,
  input  logic        cpu_cs,
  input  logic        cpu_rw,
  input  logic [7:0]  cpu_data_in,
  output logic [7:0]  cpu_data_out,
  input  logic        vblank_set,
  input  logic        vblank_clr,
  input  logic        spr0_hit_set,
  input  logic        spr_ovf_set,
  output logic        nmi,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_we,
  input  logic [7:0]  oam_rdata,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic        vram_re,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  ppu_ctrl,
  output logic [7:0]  ppu_mask,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y,
  output logic [2:0]  fine_x
);

  localparam logic [2:0] RegCtrl    = 3'd0;
  localparam logic [2:0] RegMask    = 3'd1;
  localparam logic [2:0] RegStatus  = 3'd2;
  localparam logic [2:0] RegOamAddr = 3'd3;
  localparam logic [2:0] RegOamData = 3'd4;
  localparam logic [2:0] RegScroll  = 3'd5;
  localparam logic [2:0] RegAddr    = 3'd6;
  localparam logic [2:0] RegData    = 3'd7;

  logic [7:0]  ctrl_q, ctrl_d;
  logic [7:0]  mask_q, mask_d;
  logic [7:0]  scroll_x_q, scroll_x_d;
  logic [7:0]  scroll_y_q, scroll_y_d;
  logic [2:0]  fine_x_q, fine_x_d;
  logic [13:0] t_q, t_d;
  logic [13:0] v_q, v_d;
  logic        w_q, w_d;
  logic [7:0]  oam_addr_q, oam_addr_d;
  logic [7:0]  oam_wdata_q, oam_wdata_d;
  logic        oam_we_q, oam_we_d;
  logic [7:0]  vram_wdata_q, vram_wdata_d;
  logic        vram_we_q, vram_we_d;
  logic        vram_re_q, vram_re_d;
  logic        vblank_q, vblank_d;
  logic        spr0_q, spr0_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  cpu_data_out_q, cpu_data_out_d;
  // High one cycle after vram_re: the VRAM byte is on vram_rdata this cycle.
  logic        cap_q, cap_d;
`ifdef PPU_READ_BUFFER_EN
  logic [7:0]  rbuf_q, rbuf_d;
`endif

  logic acc_wr, acc_rd, status_rd;

  // Next-state decode of CPU accesses, renderer events and lagged address increments.
  always_comb begin
    ctrl_d         = ctrl_q;
    mask_d         = mask_q;
    scroll_x_d     = scroll_x_q;
    scroll_y_d     = scroll_y_q;
    fine_x_d       = fine_x_q;
    t_d            = t_q;
    v_d            = v_q;
    w_d            = w_q;
    oam_addr_d     = oam_addr_q;
    oam_wdata_d    = oam_wdata_q;
    oam_we_d       = 1'b0;
    vram_wdata_d   = vram_wdata_q;
    vram_we_d      = 1'b0;
    vram_re_d      = 1'b0;
    cpu_data_out_d = cpu_data_out_q;
    cap_d          = vram_re_q;
    status_rd      = 1'b0;
    acc_wr         = ~cpu_cs & cpu_rw;
    acc_rd         = ~cpu_cs & ~cpu_rw;
`ifdef PPU_READ_BUFFER_EN
    rbuf_d         = rbuf_q;
    if (cap_q) rbuf_d = vram_rdata;
`else
    if (cap_q) cpu_data_out_d = vram_rdata;
`endif

    // Addresses advance the cycle after the strobe so the strobe sees the old address;
    // an explicit address load in the same cycle overrides the increment below.
    if (oam_we_q) oam_addr_d = oam_addr_q + 8'd1;
    if (vram_we_q || vram_re_q) v_d = v_q + (ctrl_q[2] ? 14'd32 : 14'd1);

    if (acc_wr) begin
      case (cpu_addr)
        RegCtrl:    ctrl_d = cpu_data_in;
        RegMask:    mask_d = cpu_data_in;
        RegOamAddr: oam_addr_d = cpu_data_in;
        RegOamData: begin
          oam_we_d    = 1'b1;
          oam_wdata_d = cpu_data_in;
        end
        RegScroll: begin
          if (!w_q) begin
            scroll_x_d = cpu_data_in;
            fine_x_d   = cpu_data_in[2:0];
          end else begin
            scroll_y_d = cpu_data_in;
          end
          w_d = ~w_q;
        end
        RegAddr: begin
          if (!w_q) begin
            t_d[13:8] = cpu_data_in[5:0];
          end else begin
            t_d[7:0] = cpu_data_in;
            v_d      = t_d;
          end
          w_d = ~w_q;
        end
        RegData: begin
          vram_we_d    = 1'b1;
          vram_wdata_d = cpu_data_in;
        end
        default: ;
      endcase
    end

    if (acc_rd) begin
      case (cpu_addr)
        RegStatus: begin
          // A vblank set landing on the read edge is reported as clear.
          cpu_data_out_d = {vblank_q & ~vblank_set, spr0_q, ovf_q, 5'b0};
          w_d            = 1'b0;
          status_rd      = 1'b1;
        end
        RegOamData: cpu_data_out_d = oam_rdata;
        RegData: begin
          vram_re_d = 1'b1;
`ifdef PPU_READ_BUFFER_EN
          cpu_data_out_d = rbuf_q;
`endif
        end
        default: cpu_data_out_d = 8'h00;
      endcase
    end

    // Flag priority: clear event, then set event, then clear-on-read.
    vblank_d = vblank_q;
    spr0_d   = spr0_q;
    ovf_d    = ovf_q;
    if (vblank_clr) begin
      vblank_d = 1'b0;
      spr0_d   = 1'b0;
      ovf_d    = 1'b0;
    end else begin
      if (vblank_set)     vblank_d = 1'b1;
      else if (status_rd) vblank_d = 1'b0;
      if (spr0_hit_set)   spr0_d   = 1'b1;
      if (spr_ovf_set)    ovf_d    = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q         <= '0;
      mask_q         <= '0;
      scroll_x_q     <= '0;
      scroll_y_q     <= '0;
      fine_x_q       <= '0;
      t_q            <= '0;
      v_q            <= '0;
      w_q            <= 1'b0;
      oam_addr_q     <= '0;
      oam_wdata_q    <= '0;
      oam_we_q       <= 1'b0;
      vram_wdata_q   <= '0;
      vram_we_q      <= 1'b0;
      vram_re_q      <= 1'b0;
      vblank_q       <= 1'b0;
      spr0_q         <= 1'b0;
      ovf_q          <= 1'b0;
      cpu_data_out_q <= '0;
      cap_q          <= 1'b0;
`ifdef PPU_READ_BUFFER_EN
      rbuf_q         <= '0;
`endif
    end else begin
      ctrl_q         <= ctrl_d;
      mask_q         <= mask_d;
      scroll_x_q     <= scroll_x_d;
      scroll_y_q     <= scroll_y_d;
      fine_x_q       <= fine_x_d;
      t_q            <= t_d;
      v_q            <= v_d;
      w_q            <= w_d;
      oam_addr_q     <= oam_addr_d;
      oam_wdata_q    <= oam_wdata_d;
      oam_we_q       <= oam_we_d;
      vram_wdata_q   <= vram_wdata_d;
      vram_we_q      <= vram_we_d;
      vram_re_q      <= vram_re_d;
      vblank_q       <= vblank_d;
      spr0_q         <= spr0_d;
      ovf_q          <= ovf_d;
      cpu_data_out_q <= cpu_data_out_d;
      cap_q          <= cap_d;
`ifdef PPU_READ_BUFFER_EN
      rbuf_q         <= rbuf_d;
`endif
    end
  end

  assign cpu_data_out = cpu_data_out_q;
  assign nmi          = vblank_q & ctrl_q[7];
  assign oam_addr     = oam_addr_q;
  assign oam_wdata    = oam_wdata_q;
  assign oam_we       = oam_we_q;
  assign vram_addr    = v_q;
  assign vram_wdata   = vram_wdata_q;
  assign vram_we      = vram_we_q;
  assign vram_re      = vram_re_q;
  assign ppu_ctrl     = ctrl_q;
  assign ppu_mask     = mask_q;
  assign scroll_x     = scroll_x_q;
  assign scroll_y     = scroll_y_q;
  assign fine_x       = fine_x_q;

endmodule

// File: tb/tb_ppu_reg_if.sv
// Testbench for ppu_reg_if: directed scenarios followed by random register traffic,
// all checked against an access-level reference model of the register file.
module tb_ppu_reg_if;

  localparam logic [2:0] RCtrl = 3'd0, RMask = 3'd1, RStatus = 3'd2, ROamAddr = 3'd3;
  localparam logic [2:0] ROamData = 3'd4, RScroll = 3'd5, RAddr = 3'd6, RData = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cpu_addr;
  logic        cpu_cs, cpu_rw;
  logic [7:0]  cpu_data_in, cpu_data_out;
  logic        vblank_set, vblank_clr, spr0_hit_set, spr_ovf_set, nmi;
  logic [7:0]  oam_addr, oam_wdata, oam_rdata;
  logic        oam_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata = 8'h00;
  logic        vram_we, vram_re;
  logic [7:0]  ppu_ctrl, ppu_mask, scroll_x, scroll_y;
  logic [2:0]  fine_x;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ppu_reg_if dut (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_cs(cpu_cs), .cpu_rw(cpu_rw),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out), .vblank_set(vblank_set),
    .vblank_clr(vblank_clr), .spr0_hit_set(spr0_hit_set), .spr_ovf_set(spr_ovf_set),
    .nmi(nmi), .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_we(oam_we),
    .oam_rdata(oam_rdata), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_we(vram_we), .vram_re(vram_re), .vram_rdata(vram_rdata), .ppu_ctrl(ppu_ctrl),
    .ppu_mask(ppu_mask), .scroll_x(scroll_x), .scroll_y(scroll_y), .fine_x(fine_x)
  );

  // Power-up VRAM contents, shared by the environment RAM and the reference model.
  function automatic logic [7:0] init_val(input int a);
    int x;
    x = ((a * 37) + 11) ^ (a >> 6);
    return x[7:0];
  endfunction

  // Synchronous VRAM: data appears the cycle after vram_re.
  logic [7:0] env_mem [int];
  always @(posedge clk) begin
    if (vram_we) env_mem[int'(vram_addr)] = vram_wdata;
    if (vram_re)
      vram_rdata <= env_mem.exists(int'(vram_addr)) ? env_mem[int'(vram_addr)]
                                                    : init_val(int'(vram_addr));
  end

  // Reference model state (updated once per clock edge, one access at a time).
  logic [7:0]  m_ctrl, m_mask, m_sx, m_sy, m_oam, m_oamw, m_vramw, m_dout, m_buf;
  logic [2:0]  m_fx;
  logic [13:0] m_t, m_v, e_vram_pa;
  logic        m_w, m_vbl, m_s0, m_ov, e_oam_we, e_vram_we, e_vram_re;
  logic [7:0]  e_oam_pa;
  logic [7:0]  ref_mem [int];
  int          m_cyc;
  int          due_cyc[$];
  logic [7:0]  due_val[$];

  function automatic logic [7:0] ref_rd(input logic [13:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(int'(a));
  endfunction

  task automatic model_reset();
    {m_ctrl, m_mask, m_sx, m_sy, m_oam, m_oamw, m_vramw, m_dout, m_buf} = '0;
    {m_fx, m_t, m_v, e_vram_pa, e_oam_pa} = '0;
    {m_w, m_vbl, m_s0, m_ov, e_oam_we, e_vram_we, e_vram_re} = '0;
    m_cyc = 0;
    due_cyc.delete();
    due_val.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all();
    chk("cpu_data_out", 32'(cpu_data_out), 32'(m_dout));
    chk("nmi", 32'(nmi), 32'(m_vbl & m_ctrl[7]));
    chk("oam_we", 32'(oam_we), 32'(e_oam_we));
    chk("oam_addr", 32'(oam_addr), 32'(e_oam_we ? e_oam_pa : m_oam));
    chk("oam_wdata", 32'(oam_wdata), 32'(m_oamw));
    chk("vram_we", 32'(vram_we), 32'(e_vram_we));
    chk("vram_re", 32'(vram_re), 32'(e_vram_re));
    chk("vram_addr", 32'(vram_addr), 32'((e_vram_we || e_vram_re) ? e_vram_pa : m_v));
    chk("vram_wdata", 32'(vram_wdata), 32'(m_vramw));
    chk("ppu_ctrl", 32'(ppu_ctrl), 32'(m_ctrl));
    chk("ppu_mask", 32'(ppu_mask), 32'(m_mask));
    chk("scroll_x", 32'(scroll_x), 32'(m_sx));
    chk("scroll_y", 32'(scroll_y), 32'(m_sy));
    chk("fine_x", 32'(fine_x), 32'(m_fx));
  endtask

  // One clock edge: drive (cs_n, addr, rw, data, {vset, vclr, s0set, ovfset}), then update model.
  task automatic step(input logic c, input logic [2:0] a, input logic r, input logic [7:0] d,
                      input logic [3:0] ev);
    logic [7:0] rv;
    logic       srd;
    cpu_cs = c; cpu_addr = a; cpu_rw = r; cpu_data_in = d;
    {vblank_set, vblank_clr, spr0_hit_set, spr_ovf_set} = ev;
    @(posedge clk);
    #1;
    cpu_cs = 1'b1;
    {vblank_set, vblank_clr, spr0_hit_set, spr_ovf_set} = 4'h0;
    m_cyc++;
    {e_oam_we, e_vram_we, e_vram_re} = 3'b000;
    srd = 1'b0;
    if (due_cyc.size() > 0 && due_cyc[0] == m_cyc) begin
      m_dout = due_val.pop_front();
      void'(due_cyc.pop_front());
    end
    if (!c && r) begin
      case (a)
        RCtrl:    m_ctrl = d;
        RMask:    m_mask = d;
        ROamAddr: m_oam = d;
        ROamData: begin e_oam_we = 1'b1; e_oam_pa = m_oam; m_oamw = d; m_oam = m_oam + 8'd1; end
        RScroll: begin
          if (!m_w) begin m_sx = d; m_fx = d[2:0]; end else m_sy = d;
          m_w = ~m_w;
        end
        RAddr: begin
          if (!m_w) m_t[13:8] = d[5:0]; else begin m_t[7:0] = d; m_v = m_t; end
          m_w = ~m_w;
        end
        RData: begin
          e_vram_we = 1'b1; e_vram_pa = m_v; m_vramw = d; ref_mem[int'(m_v)] = d;
          m_v = m_v + (m_ctrl[2] ? 14'd32 : 14'd1);
        end
        default: ;
      endcase
    end else if (!c) begin
      case (a)
        RStatus: begin m_dout = {m_vbl & ~ev[3], m_s0, m_ov, 5'b0}; m_w = 1'b0; srd = 1'b1; end
        ROamData: m_dout = oam_rdata;
        RData: begin
          rv = ref_rd(m_v); e_vram_re = 1'b1; e_vram_pa = m_v;
          m_v = m_v + (m_ctrl[2] ? 14'd32 : 14'd1);
`ifdef PPU_READ_BUFFER_EN
          m_dout = m_buf; m_buf = rv;
`else
          due_cyc.push_back(m_cyc + 2); due_val.push_back(rv);
`endif
        end
        default: m_dout = 8'h00;
      endcase
    end
    if (ev[2]) begin
      {m_vbl, m_s0, m_ov} = 3'b000;
    end else begin
      if (ev[3]) m_vbl = 1'b1; else if (srd) m_vbl = 1'b0;
      if (ev[1]) m_s0 = 1'b1;
      if (ev[0]) m_ov = 1'b1;
    end
  endtask

  task automatic idle(input logic [3:0] ev);
    step(1'b1, 3'd0, 1'b0, 8'h00, ev);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       c, r;
    logic [2:0] a;
    logic [7:0] d;
    logic [3:0] ev;
    rst_n = 1'b0; cpu_cs = 1'b1; cpu_addr = 3'd0; cpu_rw = 1'b0; cpu_data_in = 8'h00;
    {vblank_set, vblank_clr, spr0_hit_set, spr_ovf_set} = 4'h0;
    oam_rdata = 8'hC3;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all();
    rst_n = 1'b1;

    // Scroll pair, then an ADDR pair proves the toggle is back at 0.
    step(1'b0, RScroll, 1'b1, 8'h2D, 4'h0);
    step(1'b0, RScroll, 1'b1, 8'h10, 4'h0);
    chk("scroll_x_dir", 32'(scroll_x), 32'h2D);
    chk("fine_x_dir", 32'(fine_x), 32'd5);
    chk("scroll_y_dir", 32'(scroll_y), 32'h10);
    step(1'b0, RAddr, 1'b1, 8'h12, 4'h0);
    step(1'b0, RAddr, 1'b1, 8'h34, 4'h0);
    chk("w_after_scroll", 32'(vram_addr), 32'h1234);

    // Increment-by-32 back-to-back DATA writes.
    step(1'b0, RCtrl, 1'b1, 8'h04, 4'h0);
    step(1'b0, RAddr, 1'b1, 8'h21, 4'h0);
    step(1'b0, RAddr, 1'b1, 8'h08, 4'h0);
    step(1'b0, RData, 1'b1, 8'hAA, 4'h0);
    chk("we1", 32'(vram_we), 32'd1);
    chk("we1_addr", 32'(vram_addr), 32'h2108);
    step(1'b0, RData, 1'b1, 8'hAA, 4'h0);
    chk("we2", 32'(vram_we), 32'd1);
    chk("we2_addr", 32'(vram_addr), 32'h2128);
    idle(4'h0);
    chk("we_done", 32'(vram_we), 32'd0);
    chk("v_after_inc32", 32'(vram_addr), 32'h2148);
    chk_all();

    // Address wrap at the top of VRAM.
    step(1'b0, RCtrl, 1'b1, 8'h00, 4'h0);
    step(1'b0, RAddr, 1'b1, 8'h3F, 4'h0);
    step(1'b0, RAddr, 1'b1, 8'hFF, 4'h0);
    step(1'b0, RData, 1'b1, 8'h55, 4'h0);
    chk("wrap_pulse_addr", 32'(vram_addr), 32'h3FFF);
    idle(4'h0);
    chk("wrap_v", 32'(vram_addr), 32'h0000);

    // NMI, STATUS read side effects, set/clear races.
    step(1'b0, RCtrl, 1'b1, 8'h80, 4'h0);
    idle(4'b1000);
    chk("nmi_raise", 32'(nmi), 32'd1);
    step(1'b0, RStatus, 1'b0, 8'h00, 4'h0);
    chk("status_vbl", 32'(cpu_data_out), 32'h80);
    chk("nmi_cleared", 32'(nmi), 32'd0);
    step(1'b0, RAddr, 1'b1, 8'h21, 4'h0);
    step(1'b0, RStatus, 1'b0, 8'h00, 4'h0);
    step(1'b0, RAddr, 1'b1, 8'h05, 4'h0);
    step(1'b0, RAddr, 1'b1, 8'h00, 4'h0);
    chk("w_reset_by_status", 32'(vram_addr), 32'h0500);
    idle(4'b1000);
    step(1'b0, RStatus, 1'b0, 8'h00, 4'b1000);
    chk("status_set_race", 32'(cpu_data_out), 32'h00);
    chk("set_wins", 32'(nmi), 32'd1);
    idle(4'b1100);
    chk("clr_wins", 32'(nmi), 32'd0);
    idle(4'b0011);
    step(1'b0, RStatus, 1'b0, 8'h00, 4'h0);
    chk("status_spr", 32'(cpu_data_out), 32'h60);
    chk_all();

    // DATA read latency.
    step(1'b0, RAddr, 1'b1, 8'h00, 4'h0);
    step(1'b0, RAddr, 1'b1, 8'h00, 4'h0);
`ifdef PPU_READ_BUFFER_EN
    step(1'b0, RData, 1'b0, 8'h00, 4'h0);
    chk("buf_rd1", 32'(cpu_data_out), 32'h00);
    idle(4'h0); idle(4'h0);
    step(1'b0, RData, 1'b0, 8'h00, 4'h0);
    chk("buf_rd2", 32'(cpu_data_out), 32'(init_val(0)));
    idle(4'h0); idle(4'h0);
    step(1'b0, RData, 1'b0, 8'h00, 4'h0);
    chk("buf_rd3", 32'(cpu_data_out), 32'(init_val(1)));
    idle(4'h0); idle(4'h0);
`else
    step(1'b0, RData, 1'b0, 8'h00, 4'h0);
    chk("rd_hold1", 32'(cpu_data_out), 32'h60);
    step(1'b0, RData, 1'b0, 8'h00, 4'h0);
    chk("rd_hold2", 32'(cpu_data_out), 32'h60);
    step(1'b0, RData, 1'b0, 8'h00, 4'h0);
    chk("rd_data0", 32'(cpu_data_out), 32'(init_val(0)));
    idle(4'h0);
    chk("rd_data1", 32'(cpu_data_out), 32'(init_val(1)));
    idle(4'h0);
    chk("rd_data2", 32'(cpu_data_out), 32'(init_val(2)));
`endif
    chk_all();

    // OAM address wrap after a data write.
    step(1'b0, ROamAddr, 1'b1, 8'hFF, 4'h0);
    step(1'b0, ROamData, 1'b1, 8'h5A, 4'h0);
    chk("oam_we_pulse", 32'(oam_we), 32'd1);
    chk("oam_we_addr", 32'(oam_addr), 32'hFF);
    chk("oam_wdata_dir", 32'(oam_wdata), 32'h5A);
    idle(4'h0);
    chk("oam_addr_wrap", 32'(oam_addr), 32'h00);
    chk("oam_we_end", 32'(oam_we), 32'd0);

    // Reset asserted while a DATA read capture is in flight.
    step(1'b0, RAddr, 1'b1, 8'h00, 4'h0);
    step(1'b0, RAddr, 1'b1, 8'h01, 4'h0);
    step(1'b0, RData, 1'b0, 8'h00, 4'h0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all();
    idle(4'h0);
    rst_n = 1'b1;
    idle(4'h0); chk_all();
    idle(4'h0); chk_all();
    chk("capture_dropped", 32'(cpu_data_out), 32'h00);

    // Random register traffic against the reference model.
    for (int i = 0; i < 320; i++) begin
      c  = ($urandom_range(0, 3) == 0);
      a  = 3'($urandom_range(0, 7));
      r  = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      ev = 4'($urandom) & 4'($urandom) & 4'($urandom);
      oam_rdata = 8'($urandom);
      step(c, a, r, d, ev);
      chk_all();
`ifdef PPU_READ_BUFFER_EN
      if (!c && !r && a == RData) begin
        idle(4'h0); chk_all();
        idle(4'h0); chk_all();
      end
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
